// File: rtl/systolic_sequencer.sv
// Operand sequencer for a 4x4 output-stationary systolic array.
// Latches A/B tiles, injects skewed rows/columns, waits out drain, pulses done.
module systolic_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stall,
    input  logic [16*DATA_WIDTH-1:0] a_mat,
    input  logic [16*DATA_WIDTH-1:0] b_mat,
    output logic [4*DATA_WIDTH-1:0]  left_data,
    output logic [3:0]               left_valid,
    output logic [4*DATA_WIDTH-1:0]  top_data,
    output logic [3:0]               top_valid,
    output logic                     array_clear,
    output logic                     array_pause,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [2:0] T_FEED_LAST  = 3'd6;
    localparam logic [2:0] T_DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    state_t                    state_q, state_d;
    logic [2:0]                t_q, t_d;
    logic [16*DATA_WIDTH-1:0]  a_q, a_d;
    logic [16*DATA_WIDTH-1:0]  b_q, b_d;
    logic [2:0]                k;

    // State, skew counter and operand tiles
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Next-state sequencing; stall freezes the counter in FEED and DRAIN
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    a_d     = a_mat;
                    b_d     = b_mat;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                t_d     = '0;
            end
            S_FEED: begin
                if (!stall) begin
                    if (t_q == T_FEED_LAST) begin
                        state_d = S_DRAIN;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + 3'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (!stall) begin
                    if (t_q == T_DRAIN_LAST) begin
                        state_d = S_DONE;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
                t_d = '0;
                if (start) begin
                    state_d = S_CLEAR;
                    a_d     = a_mat;
                    b_d     = b_mat;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Skewed edge injection: lane n carries operand index t-n while in range
    always_comb begin
        left_data  = '0;
        left_valid = '0;
        top_data   = '0;
        top_valid  = '0;
        k          = '0;
        if (state_q == S_FEED) begin
            for (int n = 0; n < 4; n++) begin
                k = t_q - 3'(n);
                if ((t_q >= 3'(n)) && (k <= 3'd3)) begin
                    left_valid[n] = 1'b1;
                    left_data[n*DATA_WIDTH +: DATA_WIDTH] =
                        a_q[(n*4 + int'(k[1:0]))*DATA_WIDTH +: DATA_WIDTH];
                    top_valid[n] = 1'b1;
                    top_data[n*DATA_WIDTH +: DATA_WIDTH] =
                        b_q[(int'(k[1:0])*4 + n)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign array_clear = (state_q == S_CLEAR);
    assign array_pause = stall & ((state_q == S_FEED) | (state_q == S_DRAIN));
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer: vector table for the basic run,
// hand-written sequences for stall, ignored start, back-to-back and reset.
module tb_systolic_sequencer;

    localparam int DW = 16;
    localparam int DC = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stall;
    logic [16*DW-1:0]  a_mat;
    logic [16*DW-1:0]  b_mat;
    logic [4*DW-1:0]   left_data;
    logic [3:0]        left_valid;
    logic [4*DW-1:0]   top_data;
    logic [3:0]        top_valid;
    logic              array_clear;
    logic              array_pause;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [16*DW-1:0]  a_ref;
    logic [16*DW-1:0]  b_ref;
    logic [DW-1:0]     rs [4][4];
    logic [DW-1:0]     cs [4][4];
    int                rc [4];
    int                cc [4];

    typedef struct {
        logic        start;
        logic [3:0]  lv;
        logic [3:0]  tv;
        logic [63:0] ld;
        logic [63:0] td;
        logic        busy;
        logic        done;
        logic        clr;
    } vec_t;

    vec_t tab [15];

    systolic_sequencer #(
        .DATA_WIDTH   (DW),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .a_mat       (a_mat),
        .b_mat       (b_mat),
        .left_data   (left_data),
        .left_valid  (left_valid),
        .top_data    (top_data),
        .top_valid   (top_valid),
        .array_clear (array_clear),
        .array_pause (array_pause),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mv(input logic s, input logic [3:0] lv,
                                input logic [3:0] tv, input logic [63:0] ld,
                                input logic [63:0] td, input logic bz,
                                input logic dn, input logic cl);
        vec_t v;
        v.start = s;
        v.lv    = lv;
        v.tv    = tv;
        v.ld    = ld;
        v.td    = td;
        v.busy  = bz;
        v.done  = dn;
        v.clr   = cl;
        return v;
    endfunction

    // 0: 1..16 row-major, 1: identity, 2: (i+1)*(c+3), 3: r+2c+1, 4: ones
    function automatic logic [16*DW-1:0] mk_mat(input int sel);
        logic [16*DW-1:0] m;
        int v;
        m = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                case (sel)
                    0:       v = r*4 + c + 1;
                    1:       v = (r == c) ? 1 : 0;
                    2:       v = (r + 1) * (c + 3);
                    3:       v = r + 2*c + 1;
                    default: v = 1;
                endcase
                m[(r*4 + c)*DW +: DW] = DW'(v);
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] cref(input int i, input int j);
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < 4; k++)
            s += 32'(a_ref[(i*4 + k)*DW +: DW]) * 32'(b_ref[(k*4 + j)*DW +: DW]);
        return s;
    endfunction

    function automatic logic [159:0] all_out();
        return 160'({left_data, top_data, left_valid, top_valid,
                     array_clear, array_pause, busy, done});
    endfunction

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clear_cap();
        for (int i = 0; i < 4; i++) begin
            rc[i] = 0;
            cc[i] = 0;
            for (int k = 0; k < 4; k++) begin
                rs[i][k] = '0;
                cs[i][k] = '0;
            end
        end
    endtask

    // Record each unstalled edge injection in arrival order per lane
    task automatic capture();
        for (int i = 0; i < 4; i++) begin
            if (left_valid[i] && !array_pause) begin
                if (rc[i] < 4) rs[i][rc[i]] = left_data[i*DW +: DW];
                rc[i]++;
            end
            if (top_valid[i] && !array_pause) begin
                if (cc[i] < 4) cs[i][cc[i]] = top_data[i*DW +: DW];
                cc[i]++;
            end
        end
    endtask

    // PE(i,j) sees the k-th row-i operand meet the k-th column-j operand
    task automatic check_c(input string nm);
        logic [127:0] got;
        logic [127:0] want;
        logic [31:0]  s;
        logic [31:0]  sl;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 32'd0;
                for (int k = 0; k < 4; k++)
                    s += 32'(rs[i][k]) * 32'(cs[j][k]);
                got[j*32 +: 32]  = s;
                want[j*32 +: 32] = cref(i, j);
            end
            chk($sformatf("%s_C_row%0d", nm, i), 160'(got), 160'(want));
        end
        sl = '0;
        for (int i = 0; i < 4; i++) begin
            sl[i*4 +: 4]      = 4'(rc[i]);
            sl[16 + i*4 +: 4] = 4'(cc[i]);
        end
        chk($sformatf("%s_slots", nm), 160'(sl), 160'(32'h4444_4444));
    endtask

    // Assert start for one cycle, then scramble the tile inputs
    task automatic launch(input logic [16*DW-1:0] a, input logic [16*DW-1:0] b);
        clear_cap();
        a_ref = a;
        b_ref = b;
        a_mat = a;
        b_mat = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_mat = ~a;
        b_mat = ~b;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Follow a run from cycle 1 to done; returns at the done cycle's negedge
    task automatic track(input string nm, input int st_c, input int st_n,
                         input int g1, input int g2, input int exp_done,
                         input bit frz, input logic [135:0] frz_v);
        int cyc;
        bit seen;
        int nbusy;
        int npause;
        bit exp_p;
        cyc    = 1;
        seen   = 1'b0;
        nbusy  = 0;
        npause = 0;
        while (!seen && cyc <= 40) begin
            stall = (cyc >= st_c) && (cyc < st_c + st_n);
            start = (cyc == g1) || (cyc == g2);
            @(negedge clk);
            capture();
            if (!busy) nbusy++;
            exp_p = stall && (cyc >= 2) && (cyc < exp_done);
            if (array_pause !== exp_p) npause++;
            if (cyc == 1)
                chk({nm, "_clear"}, 160'(array_clear), 160'(1'b1));
            if (frz && (cyc >= st_c) && (cyc <= st_c + st_n))
                chk($sformatf("%s_frozen_c%0d", nm, cyc),
                    160'({left_valid, top_valid, left_data, top_data}),
                    160'(frz_v));
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        stall = 1'b0;
        start = 1'b0;
        chk({nm, "_done_cycle"}, 160'(cyc), 160'(exp_done));
        chk({nm, "_busy"}, 160'(nbusy), 160'(0));
        chk({nm, "_pause"}, 160'(npause), 160'(0));
    endtask

    initial begin
        int nd;
        int ncl;

        tab[0]  = mv(1'b1, 4'b0000, 4'b0000, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        tab[1]  = mv(1'b0, 4'b0000, 4'b0000, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1);
        tab[2]  = mv(1'b0, 4'b0001, 4'b0001, 64'h0000_0000_0000_0001,
                     64'h0000_0000_0000_0001, 1'b1, 1'b0, 1'b0);
        tab[3]  = mv(1'b0, 4'b0011, 4'b0011, 64'h0000_0000_0005_0002,
                     64'h0, 1'b1, 1'b0, 1'b0);
        tab[4]  = mv(1'b0, 4'b0111, 4'b0111, 64'h0000_0009_0006_0003,
                     64'h0000_0000_0001_0000, 1'b1, 1'b0, 1'b0);
        tab[5]  = mv(1'b0, 4'b1111, 4'b1111, 64'h000d_000a_0007_0004,
                     64'h0, 1'b1, 1'b0, 1'b0);
        tab[6]  = mv(1'b0, 4'b1110, 4'b1110, 64'h000e_000b_0008_0000,
                     64'h0000_0001_0000_0000, 1'b1, 1'b0, 1'b0);
        tab[7]  = mv(1'b0, 4'b1100, 4'b1100, 64'h000f_000c_0000_0000,
                     64'h0, 1'b1, 1'b0, 1'b0);
        tab[8]  = mv(1'b0, 4'b1000, 4'b1000, 64'h0010_0000_0000_0000,
                     64'h0001_0000_0000_0000, 1'b1, 1'b0, 1'b0);
        for (int c = 9; c <= 12; c++)
            tab[c] = mv(1'b0, 4'b0000, 4'b0000, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        tab[13] = mv(1'b0, 4'b0000, 4'b0000, 64'h0, 64'h0, 1'b1, 1'b1, 1'b0);
        tab[14] = mv(1'b0, 4'b0000, 4'b0000, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);

        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        a_mat = '0;
        b_mat = '0;
        clear_cap();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_out(), 160'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic run from the vector table: A = 1..16, B = identity
        a_ref = mk_mat(0);
        b_ref = mk_mat(1);
        for (int c = 0; c < 15; c++) begin
            start = tab[c].start;
            a_mat = (c == 0) ? a_ref : ~a_ref;
            b_mat = (c == 0) ? b_ref : ~b_ref;
            @(negedge clk);
            capture();
            chk($sformatf("basic_data_c%0d", c),
                160'({left_data, top_data}), 160'({tab[c].ld, tab[c].td}));
            chk($sformatf("basic_ctl_c%0d", c),
                160'({left_valid, top_valid, busy, done, array_clear, array_pause}),
                160'({tab[c].lv, tab[c].tv, tab[c].busy, tab[c].done,
                      tab[c].clr, 1'b0}));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check_c("basic");

        // Two stalled cycles at FEED t=3 hold the t=3 edge values
        launch(mk_mat(0), mk_mat(1));
        track("stall", 5, 2, -1, -1, 15, 1'b1,
              {4'b1111, 4'b1111, 64'h000d_000a_0007_0004, 64'h0});
        idle();
        check_c("stall");

        // Stall in CLEAR ignored; start pulses in FEED/DRAIN ignored
        launch(mk_mat(2), mk_mat(3));
        track("ignore", 1, 1, 5, 10, 13, 1'b0, '0);
        idle();
        check_c("ignore");

        // Back-to-back: start held in DONE
        launch(mk_mat(0), mk_mat(4));
        track("b2b_1", -1, 0, -1, -1, 13, 1'b0, '0);
        check_c("b2b_1");
        launch(mk_mat(2), mk_mat(1));
        track("b2b_2", -1, 0, -1, -1, 13, 1'b0, '0);
        idle();
        check_c("b2b_2");

        // Reset at FEED t=2 aborts the run silently
        launch(mk_mat(0), mk_mat(1));
        repeat (3) idle();
        @(negedge clk);
        chk("rst_pre_lv", 160'(left_valid), 160'(4'b0111));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_outputs", all_out(), 160'(0));
        nd  = 0;
        ncl = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) nd++;
            if (array_clear) ncl++;
        end
        chk("rst_no_done", 160'(nd), 160'(0));
        chk("rst_no_clear", 160'(ncl), 160'(0));
        idle();
        launch(mk_mat(2), mk_mat(3));
        track("after_rst", -1, 0, -1, -1, 13, 1'b0, '0);
        idle();
        check_c("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Sequencer for the 4x4 output-stationary systolic array in the compute unit. It latches one A tile and one B tile on `start` and clears the array accumulators. It then injects A rows at the left edge and B columns at the top edge with the diagonal skew the array requires, driving the edge valid bits. Finally it waits out the pipeline drain and pulses `done` once all 16 results are final. It also converts a downstream/upstream `stall` into the array's `pause`.

## Interface
- `DATA_WIDTH`, 16, operand element width.
- `DRAIN_CYCLES`, 4, cycles waited after the last injection before results are final (array hop depth + MAC register).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1  request a tile multiply; sampled only in IDLE or DONE.
- `stall`  in  1  freeze sequencing and pause the array.
- `a_mat`  in  16*DATA_WIDTH  A[i][k] at bits [(i*4+k)*DATA_WIDTH +: DATA_WIDTH].
- `b_mat`  in  16*DATA_WIDTH  B[k][j] at bits [(k*4+j)*DATA_WIDTH +: DATA_WIDTH].
- `left_data`  out  4*DATA_WIDTH  lane i ([i*DATA_WIDTH +: DATA_WIDTH]) drives array row i left input (lane 0 = corner).
- `left_valid`  out  4  per-row valid (bit 0 = corner valid).
- `top_data`  out  4*DATA_WIDTH  lane j drives array column j top input (lane 0 = corner).
- `top_valid`  out  4  per-column valid.
- `array_clear`  out  1  reset pulse to array accumulators.
- `array_pause`  out  1  pause to array.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; array results valid.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE; 3-bit cycle counter `t`; operand registers `a_q`, `b_q`.
- IDLE: `start`=1 → latch `a_mat`/`b_mat` into `a_q`/`b_q`, go to CLEAR.
- CLEAR: exactly one cycle, `array_clear`=1, ignores `stall`; `t`←0; → FEED.
- FEED: `t` runs 0..6.
  - Row i: `left_valid[i]`=1 and lane i = A[i][t−i] iff 0 ≤ t−i ≤ 3; else valid 0 and data 0.
  - Column j: `top_valid[j]`=1 and lane j = B[t−j][j] iff 0 ≤ t−j ≤ 3; else valid 0 and data 0.
  - At t=6, unstalled → DRAIN with `t`←0.
- DRAIN: all valids 0, data 0; counts `t` 0..DRAIN_CYCLES−1 → DONE.
- DONE: `done`=1 for one cycle.
  - `start`=1 here → latch operands, go to CLEAR (back-to-back).
  - Otherwise → IDLE.
- `start` in CLEAR/FEED/DRAIN is ignored; operands are not relatched.
- Stall: `array_pause` = `stall` & (FEED | DRAIN).
  - While stalled, `t` and state hold; edge data and valids hold their current values.
  - `stall` in IDLE, CLEAR or DONE has no effect and `array_pause`=0.
- Edge data/valid decode combinationally from state, `t`, `a_q`, `b_q` (no added latency); state, counter and operand registers are the only flops.

## Timing
- Reset: state IDLE, `t`=0, `a_q`=`b_q`=0; all outputs 0 (`busy`, `done`, `array_clear`, `array_pause`, all data/valid).
- Reset mid-operation: next cycle IDLE with outputs 0; no `done`; `array_clear` is not issued.
- No stall, `start` high in cycle 0:
  - CLEAR in cycle 1.
  - FEED in cycles 2–8.
  - DRAIN in cycles 9..8+DRAIN_CYCLES.
  - `done` in cycle 9+DRAIN_CYCLES (13 at default).
- Each stalled cycle in FEED/DRAIN adds exactly one cycle to latency.
- `busy` rises the cycle after `start` is accepted. It stays high through DONE, falls in IDLE, and stays high across a back-to-back start.
- Each A[i][k] and B[k][j] is asserted valid for exactly one unstalled FEED cycle: 16 row slots, 16 column slots per tile.

## Test plan
- Basic: A = elements 1..16 row-major, B = identity, no stall.
  - `left_valid` per FEED t=0..6: 0001, 0011, 0111, 1111, 1110, 1100, 1000; same for `top_valid`.
  - Lane 0 carries 1,2,3,4 at t=0..3.
  - `done` in cycle 13; the array model yields C = A.
- Stall at FEED t=3 for 2 cycles:
  - `array_pause`=1 for exactly those 2 cycles; edge data/valid frozen at the t=3 values.
  - `done` in cycle 15.
- `start` pulsed during FEED and DRAIN with different `a_mat`: ignored; `done` still in cycle 13; results use the originally latched A.
- `a_mat`/`b_mat` changed the cycle after `start`: injected values equal the values present on the `start` cycle.
- Back-to-back: `start` held high during DONE.
  - Next cycle is CLEAR with `array_clear`=1; `busy` never drops.
  - Second `done` arrives 13 cycles after the first.
- `reset` asserted at FEED t=2:
  - Next cycle all outputs 0, state IDLE, no `done`.
  - A subsequent `start` runs a full sequence with `done` 13 cycles later.
